// File: rtl/mul_share_ctrl_pkg.sv
// Shared types for the shared-multiplier sequencer: FSM states, requester count
// and the owner-index encoding used by the controller and its arbiter.
package mul_share_ctrl_pkg;

    localparam int REQ_N = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Owner index: one bit is enough for exactly two requesters.
    typedef logic owner_t;
    localparam owner_t OWNER_0 = 1'b0;
    localparam owner_t OWNER_1 = 1'b1;

    function automatic logic [REQ_N-1:0] owner_onehot(input owner_t owner);
        return (owner == OWNER_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier sequencer.
// slave is the controller's view; master is the surrounding logic's view.
interface mul_share_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req;
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b1;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic [2*WIDTH-1:0] res;
    logic               busy;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_finish;
    logic [2*WIDTH-1:0] mul_res;

    modport slave (
        input  req, a0, b0, a1, b1, mul_finish, mul_res,
        output gnt, done, res, busy, mul_start, mul_a, mul_b
    );

    modport master (
        output req, a0, b0, a1, b1, mul_finish, mul_res,
        input  gnt, done, res, busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-way arbiter: round-robin by default, fixed priority to requester 0 when
// MUL_SHARE_FIXED_PRIO_EN is defined (the priority pointer then disappears).
module rr_arb2
    import mul_share_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  owner_t     upd_owner,
    output logic       any,
    output owner_t     win
);

    assign any = |req;

`ifdef MUL_SHARE_FIXED_PRIO_EN
    logic unused;
    assign unused = ^{clk, rst, upd, upd_owner};
    assign win    = req[0] ? OWNER_0 : OWNER_1;
`else
    owner_t prio;

    // After a completion the other requester is favoured next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= OWNER_0;
        end else if (upd) begin
            prio <= ~upd_owner;
        end
    end

    always_comb begin
        win = prio;
        if (!req[prio]) begin
            win = ~prio;
        end
    end
`endif

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequences one start/finish multiplier between two requesters. Arbitration
// mode is selected by MUL_SHARE_FIXED_PRIO_EN (see rr_arb2).
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REQ_N = 2
) (
    input logic             clk,
    input logic             rst,
    mul_share_ctrl_if.slave bus
);

    generate
        if (REQ_N != mul_share_ctrl_pkg::REQ_N) begin : g_req_n_check
            $error("mul_share_ctrl supports exactly two requesters");
        end
    endgenerate

    state_t             state;
    state_t             state_nx;
    owner_t             owner;
    owner_t             win;
    logic               any;
    logic               done_stb;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] res;

    assign done_stb = (state == DONE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .upd       (done_stb),
        .upd_owner (owner),
        .any       (any),
        .win       (win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.mul_finish) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant is decoded in IDLE so a new job can start the cycle after DONE;
    // it is gated by rst so nothing is granted while reset is held.
    always_comb begin
        gnt       = 2'b00;
        done      = 2'b00;
        mul_start = 1'b0;
        case (state)
            IDLE:    if (any && rst) gnt = owner_onehot(win);
            ISSUE:   mul_start = 1'b1;
            DONE:    done = owner_onehot(owner);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= OWNER_0;
            mul_a <= '0;
            mul_b <= '0;
            res   <= '0;
        end else begin
            if (state == IDLE && any) begin
                owner <= win;
                mul_a <= (win == OWNER_1) ? bus.a1 : bus.a0;
                mul_b <= (win == OWNER_1) ? bus.b1 : bus.b0;
            end
            if (state == WAIT && bus.mul_finish) begin
                res <= bus.mul_res;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.done      = done;
    assign bus.mul_start = mul_start;
    assign bus.busy      = (state != IDLE) || (|gnt);
    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.res       = res;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a 4-cycle multiplier model; the
// arbitration expectations follow MUL_SHARE_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_mul_share_ctrl;

    localparam int WIDTH = 4;
    localparam int LAT   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mul_share_ctrl #(.WIDTH(WIDTH), .REQ_N(2)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Multiplier model: finish pulses LAT cycles after the start cycle.
    logic       model_fin;
    logic       spur_fin;
    logic [7:0] model_res;
    logic [7:0] prod;
    int         mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt      <= 0;
            model_fin <= 1'b0;
            model_res <= '0;
            prod      <= '0;
        end else begin
            model_fin <= 1'b0;
            if (bus.mul_start) begin
                mcnt <= LAT - 1;
                prod <= bus.mul_a * bus.mul_b;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    model_fin <= 1'b1;
                    model_res <= prod;
                end
            end
        end
    end

    assign bus.mul_finish = model_fin | spur_fin;
    assign bus.mul_res    = model_res;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [1:0] gq[$];
    logic [7:0] oq[$];
    logic [9:0] dq[$];

    task automatic expect_job(input logic [1:0] g, input logic [3:0] a, input logic [3:0] b,
                              input logic [7:0] r);
        gq.push_back(g);
        oq.push_back({a, b});
        dq.push_back({g, r});
    endtask

    int cyc  = 0;
    int gcyc = -100;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (|bus.gnt) begin
                if (gq.size() == 0) chk("unexpected_gnt", bus.gnt, 0);
                else                chk("gnt", bus.gnt, gq.pop_front());
                gcyc = cyc;
            end
            if (bus.mul_start) begin
                chk("start_latency", cyc - gcyc, 1);
                if (oq.size() == 0) chk("unexpected_start", bus.mul_start, 0);
                else                chk("mul_ab", {bus.mul_a, bus.mul_b}, oq.pop_front());
            end
            if (|bus.done) begin
                chk("done_latency", cyc - gcyc, 2 + LAT);
                if (dq.size() == 0) chk("unexpected_done", bus.done, 0);
                else                chk("done_res", {bus.done, bus.res}, dq.pop_front());
            end
        end
    end

    task automatic wait_gnt();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (|bus.gnt) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout actual=none required=grant");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (|bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    task automatic finish_job();
        wait_done();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mul_start"}, bus.mul_start, 0);
        chk({tag, "_mul_a"}, bus.mul_a, 0);
        chk({tag, "_mul_b"}, bus.mul_b, 0);
        chk({tag, "_res"}, bus.res, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 2'b00;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        spur_fin = 1'b0;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 0.
        expect_job(2'b01, 4'd3, 4'd5, 8'd15);
        bus.a0 = 4'd3; bus.b0 = 4'd5; bus.req = 2'b01;
        wait_gnt();
        bus.req = 2'b00;
        wait_done();
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        @(posedge clk); #1;

        // Requester 1 alone; also leaves the pointer favouring requester 0.
        expect_job(2'b10, 4'd2, 4'd6, 8'd12);
        bus.a1 = 4'd2; bus.b1 = 4'd6; bus.req = 2'b10;
        wait_gnt();
        bus.req = 2'b00;
        finish_job();

        // Both requesting continuously for three operations.
`ifdef MUL_SHARE_FIXED_PRIO_EN
        expect_job(2'b01, 4'd7, 4'd9, 8'd63);
        expect_job(2'b01, 4'd7, 4'd9, 8'd63);
        expect_job(2'b01, 4'd7, 4'd9, 8'd63);
`else
        expect_job(2'b01, 4'd7, 4'd9, 8'd63);
        expect_job(2'b10, 4'd15, 4'd15, 8'd225);
        expect_job(2'b01, 4'd7, 4'd9, 8'd63);
`endif
        bus.a0 = 4'd7; bus.b0 = 4'd9; bus.a1 = 4'd15; bus.b1 = 4'd15; bus.req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_gnt();
            if (i == 2) bus.req = 2'b00;
            finish_job();
        end

        // Operands change after the grant; latched values must be used.
        expect_job(2'b01, 4'd3, 4'd5, 8'd15);
        bus.a0 = 4'd3; bus.b0 = 4'd5; bus.req = 2'b01;
        wait_gnt();
        bus.req = 2'b00;
        bus.a0  = 4'd8;
        finish_job();

        // Zero operand; a request raised and dropped while busy is never granted.
        expect_job(2'b01, 4'd0, 4'd15, 8'd0);
        bus.a0 = 4'd0; bus.b0 = 4'd15; bus.req = 2'b01;
        wait_gnt();
        bus.req = 2'b10; bus.a1 = 4'd15; bus.b1 = 4'd15;
        repeat (2) @(posedge clk);
        #1 bus.req = 2'b00;
        finish_job();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_after_drop_busy", bus.busy, 0);
            chk("idle_after_drop_gnt", bus.gnt, 0);
        end
        @(posedge clk); #1;

        // Maximum operands.
        expect_job(2'b10, 4'd15, 4'd15, 8'd225);
        bus.req = 2'b10;
        wait_gnt();
        bus.req = 2'b00;
        finish_job();

        // Spurious finish while idle.
        spur_fin = 1'b1;
        @(posedge clk);
        #1 spur_fin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spurious_done", bus.done, 0);
            chk("spurious_busy", bus.busy, 0);
        end
        @(posedge clk); #1;

        // Reset during WAIT abandons the job.
        gq.push_back(2'b01);
        oq.push_back({4'd9, 4'd9});
        bus.a0 = 4'd9; bus.b0 = 4'd9; bus.req = 2'b01;
        wait_gnt();
        bus.req = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_wait_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", bus.done, 0);
        end
        @(posedge clk); #1;

        expect_job(2'b10, 4'd2, 4'd6, 8'd12);
        bus.a1 = 4'd2; bus.b1 = 4'd6; bus.req = 2'b10;
        wait_gnt();
        bus.req = 2'b00;
        finish_job();

        repeat (3) @(posedge clk);
        chk("gq_drained", gq.size(), 0);
        chk("oq_drained", oq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequences a single shared start/finish multiplier (MUL-style, WIDTH-bit operands, 2*WIDTH-bit result) between two requesters.
Arbitrates requests round-robin and latches the winner's operands. It then pulses the multiplier start, waits for finish, and returns the product with a per-requester done pulse.
Sits between the multiplier instance and the requesting logic, e.g. a switch-input front end and the Segment display path, in board top levels.

Parameters:
WIDTH, 4, operand width in bits; result width is 2*WIDTH.
REQ_N, 2, number of requesters; fixed at 2, any other value is a synthesis error.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-low.
req  input  2  request per requester; bit i is held high with a_i/b_i stable until gnt[i].
a0  input  WIDTH  requester 0 multiplicand.
b0  input  WIDTH  requester 0 multiplier.
a1  input  WIDTH  requester 1 multiplicand.
b1  input  WIDTH  requester 1 multiplier.
gnt  output  2  one-cycle grant pulse; operands are captured in that cycle.
done  output  2  one-cycle completion pulse for the owning requester.
res  output  2*WIDTH  product; valid while done is high, held until the next completion.
busy  output  1  high from grant through the done cycle.
mul_start  output  1  one-cycle start pulse to the multiplier.
mul_a  output  WIDTH  latched multiplicand to the multiplier.
mul_b  output  WIDTH  latched multiplier to the multiplier.
mul_finish  input  1  multiplier finish pulse.
mul_res  input  2*WIDTH  multiplier result; sampled when mul_finish is high.

Behaviour:
- Reset (rst low, async): state=IDLE; gnt, done, busy, mul_start = 0; mul_a, mul_b, res = 0; prio pointer = 0 (requester 0 favoured). Reset during WAIT abandons the operation and no done is issued. The multiplier shares rst and resets too.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set: assert gnt[w] for one cycle, latch a_w/b_w into mul_a/mul_b, record owner=w, go to ISSUE.
  - Winner w: the requester with priority if it requests, else the other.
  - If req==0, stay in IDLE.
- ISSUE: mul_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - Hold mul_a/mul_b stable; ignore req.
  - On mul_finish=1: capture mul_res into res and go to DONE.
  - mul_finish is sampled only in WAIT; a finish in the ISSUE cycle is ignored.
- DONE:
  - done[owner]=1 for one cycle; prio pointer set to the other requester; go to IDLE.
  - A new grant is possible in the next cycle, so the minimum gap between grants is 3 + multiplier latency cycles.
- busy=1 in ISSUE, WAIT and DONE, and in the grant cycle (registered with the IDLE→ISSUE transition).
- A requester that drops req before being granted is never granted; no request is queued beyond its live req level.
- Requests arriving while busy wait for IDLE; no starvation, since both requesting always alternates.
- Arithmetic: no width conversion; res = mul_res bit-exact, 2*WIDTH bits.
- Latency from grant to done = 2 + N cycles, where N is the multiplier cycles from start to finish.

Optional Feature:
MUL_SHARE_FIXED_PRIO_EN:
- Defined: fixed priority, requester 0 always wins simultaneous requests; the prio pointer is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, WAIT, DONE), REQ_N=2, encoding of the owner index.
- One sub-module: rr_arb2 (2-way round-robin, or fixed under the macro). Combinational grant from req and prio; prio register update on a done strobe.
- FSM and operand/result registers stay in mul_share_ctrl.

Test Plan (WIDTH=4, multiplier model with 4-cycle latency):
- req=01, a0=3, b0=5 → gnt=01 one cycle, mul_start one cycle later, done=01 with res=15; busy low the cycle after done.
- req=11 simultaneous, a0=7 b0=9, a1=15 b1=15 → req0 served first (res=63, done=01), then req1 (res=225, done=10). Repeating req=11 serves req0 next.
- With MUL_SHARE_FIXED_PRIO_EN defined, req held at 11 for three operations → gnt=01 all three times.
- rst pulled low mid-WAIT → all outputs 0 immediately, no done. After rst high, req=10 with a1=2, b1=6 → res=12.
- Operands change after gnt (a0=3→8) → mul_a stays 3, res=15; req dropped before grant → no gnt, FSM stays IDLE.
- Zero/max operands: a0=0, b0=15 → res=0; a1=15, b1=15 → res=225; spurious mul_finish in IDLE → ignored, no done.
